// File: rtl/victim_wb_ctrl_pkg.sv
// rtl/victim_wb_ctrl_pkg.sv - shared cache types and line geometry for the victim write-back path
package victim_wb_ctrl_pkg;
  localparam int PHYS_WIDTH = 32;

  typedef logic [PHYS_WIDTH-1:0] phys_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} victim_wb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int line_byte_offset(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int label_width(input int line_width);
    return PHYS_WIDTH - line_byte_offset(line_width);
  endfunction
endpackage

// File: rtl/victim_wb_ctrl.sv
// rtl/victim_wb_ctrl.sv - drains victim lines to memory as single INCR write bursts
// Optional VICTIM_WB_PERF_EN adds the wb_count write-back counter.
module victim_wb_ctrl
  import victim_wb_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BUS_WIDTH   = 32,
  parameter int LABEL_WIDTH = label_width(LINE_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] vc_rline,
  input  logic                          vc_empty,
  output logic                          vc_pop,
  output logic                          inflight_valid,
  output logic [LABEL_WIDTH-1:0]        inflight_label,
  input  logic                          flush_req,
  output logic                          flush_done,
  output phys_t                         awaddr,
  output logic [7:0]                    awlen,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [BUS_WIDTH-1:0]          wdata,
  output logic [BUS_WIDTH/8-1:0]        wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic                          bvalid,
  output logic                          bready
`ifdef VICTIM_WB_PERF_EN
  ,
  output logic [31:0]                   wb_count
`endif
);

  localparam int BEATS    = LINE_WIDTH / BUS_WIDTH;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int OFFSET_W = line_byte_offset(LINE_WIDTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  victim_wb_state_t                  state;
  logic [LABEL_WIDTH+LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0]             data_q;
  logic [BEAT_W-1:0]                 beat;

  // Everything driven onto the bus comes from line_q, so it cannot move while a valid waits.
  assign data_q         = line_q[LINE_WIDTH-1:0];
  assign inflight_label = line_q[LABEL_WIDTH+LINE_WIDTH-1 -: LABEL_WIDTH];
  assign awaddr         = {inflight_label, {OFFSET_W{1'b0}}};
  assign awlen          = 8'(BEATS - 1);
  assign wstrb          = '1;
  assign wdata          = data_q[int'(beat)*BUS_WIDTH +: BUS_WIDTH];
  assign wlast          = (beat == LAST_BEAT);
  assign vc_pop         = (state == RESP) && bvalid && !vc_empty;
  assign flush_done     = flush_req && vc_empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      line_q         <= '0;
      beat           <= '0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      inflight_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!vc_empty) begin
            line_q         <= vc_rline;
            inflight_valid <= 1'b1;
            awvalid        <= 1'b1;
            state          <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            beat    <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            if (beat == LAST_BEAT) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              beat   <= '0;
              state  <= RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        RESP: begin
          // Returning through IDLE guarantees a gap cycle before the next line is latched.
          if (bvalid) begin
            bready         <= 1'b0;
            inflight_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VICTIM_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (vc_pop) begin
      wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
